dif_radix2_sdf_pe: RTL and testbench
====================================

// Module: dif_radix2_sdf_pe
// PURPOSE
//  One radix-2 decimation-in-frequency single-path delay-feedback (R2SDF) stage for a pipelined FFT.
//  Per frame: the first FIFO_DEPTH samples are buffered. The next FIFO_DEPTH samples are butterflied
//  against them, and sums go out directly. Differences are fed back into the delay line and emitted
//  during the next fill phase, multiplied by a twiddle selected by tm_ctrl.
//  Complex data, signed two's complement; stages are chained dout->din by the FFT top level.
// PARAMETERS
//  DATA_WIDTH_IN   10  width of din_real/din_imag (signed)
//  DATA_WIDTH_OUT  12  width of dout_real/dout_imag (signed); must be >= DATA_WIDTH_IN+2
//  TWIDDLE_RANK     8  fractional bits of twiddle constants (1.0 = 2^TWIDDLE_RANK)
//  FIFO_DEPTH       4  delay-line length = half the butterfly span (stage size 2*FIFO_DEPTH)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous reset, active-HIGH (legacy name)
//  halt_ctrl  in   1               1 = stage advances this cycle; 0 = all state frozen
//  mux_ctrl   in   1               0 = fill/twiddle phase, 1 = butterfly phase
//  tm_ctrl    in   2               twiddle index k, W = exp(-j*2*pi*k/8)
//  din_real   in   DATA_WIDTH_IN   input sample, real
//  din_imag   in   DATA_WIDTH_IN   input sample, imaginary
//  dout_real  out  DATA_WIDTH_OUT  registered output, real
//  dout_imag  out  DATA_WIDTH_OUT  registered output, imaginary
// BEHAVIOUR
//  - Reset (rst_n=1, async): all FIFO entries = 0, dout_real = dout_imag = 0. Held while asserted.
//    Mid-frame reset discards frame state; the next frame starts from an empty (zero) FIFO.
//  - FIFO: FIFO_DEPTH-entry shift register of (DATA_WIDTH_IN+1)-bit complex words.
//    f = oldest entry. It shifts only on enabled edges (halt_ctrl=1).
//  - mux_ctrl=0: FIFO input = sign-extended din; dout <= W(tm_ctrl) * f.
//  - mux_ctrl=1: FIFO input = f - din (full precision, DATA_WIDTH_IN+1 bits); dout <= f + din, sign-extended.
//  - Twiddles (re, im):
//      k=0: (2^R, 0)
//      k=1: (C, -C)
//      k=2: (0, -2^R)
//      k=3: (-C, -C)
//    C = round(2^R/sqrt2) = 181 for R=8.
//  - Product: full-precision complex multiply, then arithmetic shift right by TWIDDLE_RANK (floor).
//    Result is sign-extended/truncated to DATA_WIDTH_OUT. No overflow at default widths:
//    |result| <= 1447.
//  - Latency: 1 clock. Inputs are sampled at edge n; the result appears on dout after edge n.
//  - halt_ctrl=0: FIFO and dout hold their values; din, mux_ctrl and tm_ctrl are ignored.
//    Resume continues exactly where the stage stopped.
//  - Control sequencing (FIFO_DEPTH cycles mux=0, then FIFO_DEPTH cycles mux=1) is driven externally.
//    The stage has no internal counter. Out-of-pattern control is applied literally, cycle by cycle.
//  - Fill phase right after reset outputs W*0 = 0.
// CONFIGURATION
//  DIF_PE_ROUND_EN defined:
//    - Add 2^(TWIDDLE_RANK-1) before the twiddle shift (round half up).
//    - Example: 84.84 -> 85.
//  Not defined:
//    - Plain floor shift, as specified above.
//  Sum path and k=0/k=2 results are exact in both builds.
// TESTING
//  1. Reset:
//     - Assert rst_n mid-stream -> dout=0 immediately (async).
//     - After release, 4 fill cycles -> dout=0.
//  2. Butterfly:
//     - Fill (mux=0) with 100+200j, 90+180j, 80+160j, 70+140j.
//     - Then mux=1 with 60+120j, 50+100j, 40+80j, 30+60j.
//     - Expected dout: 160+320j, 140+280j, 120+240j, 100+200j.
//  3. Twiddles: after test 2, mux=0 with tm_ctrl=0,1,2,3 (FIFO holds 40+80j each).
//     - Expected dout: 40+80j, 84+28j, 80-40j, 28-85j.
//     - DIF_PE_ROUND_EN: 85+28j at k=1.
//  4. Halt:
//     - Drop halt_ctrl for 3 cycles mid-butterfly while changing din.
//     - dout and FIFO are frozen; resumed outputs match the unhalted sequence.
//  5. Extremes:
//     - din = -512-512j buffered, then butterflied with 511+511j.
//     - Sum = -1-1j; diff = -1023-1023j.
//     - Next fill with k=1: dout = -1447+0j, no wrap.

Source files
------------

// File: rtl/dif_radix2_sdf_pe.sv
// Radix-2 DIF single-path delay-feedback FFT stage: delay line, butterfly and twiddle multiply.
// Optional build macro DIF_PE_ROUND_EN: round-half-up before the twiddle shift instead of floor.
module dif_radix2_sdf_pe #(
    parameter int DATA_WIDTH_IN  = 10,
    parameter int DATA_WIDTH_OUT = 12,
    parameter int TWIDDLE_RANK   = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             halt_ctrl,
    input  logic                             mux_ctrl,
    input  logic [1:0]                       tm_ctrl,
    input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
    input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
    output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
    output logic signed [DATA_WIDTH_OUT-1:0] dout_imag
);

    localparam int WF = DATA_WIDTH_IN + 1;
    localparam int WT = TWIDDLE_RANK + 2;
    localparam int WP = WF + WT + 1;

    localparam logic signed [WT-1:0] TW_ONE = WT'(2 ** TWIDDLE_RANK);
    localparam logic signed [WT-1:0] TW_C   = WT'(int'(real'(2 ** TWIDDLE_RANK) / 1.4142135623730951));

`ifdef DIF_PE_ROUND_EN
    localparam logic signed [WP-1:0] RND = WP'(2 ** (TWIDDLE_RANK - 1));
`else
    localparam logic signed [WP-1:0] RND = '0;
`endif

    typedef struct packed {
        logic signed [WF-1:0] re;
        logic signed [WF-1:0] im;
    } cword_t;

    cword_t fifo [FIFO_DEPTH];
    cword_t f;
    cword_t din_ext;
    cword_t fifo_in;

    logic signed [WT-1:0] tw_re, tw_im;
    logic signed [WP-1:0] prod_re, prod_im;
    logic signed [WP-1:0] shr_re, shr_im;
    logic signed [WF:0]   sum_re, sum_im;
    logic signed [DATA_WIDTH_OUT-1:0] next_re, next_im;

    assign f          = fifo[FIFO_DEPTH-1];
    assign din_ext.re = WF'(din_real);
    assign din_ext.im = WF'(din_imag);

    // W = exp(-j*2*pi*k/8) as fixed-point constants
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        tw_re = TW_ONE;
        tw_im = '0;
        case (tm_ctrl)
            2'd1: begin tw_re = TW_C;    tw_im = -TW_C;   end
            2'd2: begin tw_re = '0;      tw_im = -TW_ONE; end
            2'd3: begin tw_re = -TW_C;   tw_im = -TW_C;   end
            default: ;
        endcase
    end

    always_comb begin
        prod_re = WP'(f.re) * WP'(tw_re) - WP'(f.im) * WP'(tw_im);
        prod_im = WP'(f.re) * WP'(tw_im) + WP'(f.im) * WP'(tw_re);
        shr_re  = (prod_re + RND) >>> TWIDDLE_RANK;
        shr_im  = (prod_im + RND) >>> TWIDDLE_RANK;
        sum_re  = (WF + 1)'(f.re) + (WF + 1)'(din_ext.re);
        sum_im  = (WF + 1)'(f.im) + (WF + 1)'(din_ext.im);

        fifo_in = din_ext;
        next_re = DATA_WIDTH_OUT'(shr_re);
        next_im = DATA_WIDTH_OUT'(shr_im);
        if (mux_ctrl) begin
            fifo_in.re = f.re - din_ext.re;
            fifo_in.im = f.im - din_ext.im;
            next_re    = DATA_WIDTH_OUT'(sum_re);
            next_im    = DATA_WIDTH_OUT'(sum_im);
        end
    end

    // rst_n is a legacy name: it is active-high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the delay line is cleared on reset so a fresh frame never butterflies stale data.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
            dout_real <= '0;
            dout_imag <= '0;
        end else if (halt_ctrl) begin
            // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
            fifo[0] <= fifo_in;
            for (int i = 1; i < FIFO_DEPTH; i++) fifo[i] <= fifo[i-1];
            dout_real <= next_re;
            dout_imag <= next_im;
        end
    end

endmodule

// File: tb/tb_dif_radix2_sdf_pe.sv
// Directed self-checking bench for dif_radix2_sdf_pe: reset, butterfly, twiddles, halt, extremes.
module tb_dif_radix2_sdf_pe;

    logic clk = 1'b0;
    logic rst_n;
    logic halt_ctrl;
    logic mux_ctrl;
    logic [1:0] tm_ctrl;
    logic signed [9:0]  din_real, din_imag;
    logic signed [11:0] dout_real, dout_imag;

    int checks = 0;
    int errors = 0;

    dif_radix2_sdf_pe #(
        .DATA_WIDTH_IN (10),
        .DATA_WIDTH_OUT(12),
        .TWIDDLE_RANK  (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt_ctrl(halt_ctrl),
        .mux_ctrl (mux_ctrl),
        .tm_ctrl  (tm_ctrl),
        .din_real (din_real),
        .din_imag (din_imag),
        .dout_real(dout_real),
        .dout_imag(dout_imag)
    );

    always #5 clk = ~clk;

    // Apply one set of inputs, clock it in, and settle just after the edge.
    task automatic step(input logic h, input logic m, input logic [1:0] k,
                        input int re, input int im);
        halt_ctrl = h;
        mux_ctrl  = m;
        tm_ctrl   = k;
        din_real  = 10'(re);
        din_imag  = 10'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int exp_re, input int exp_im);
        logic signed [11:0] er, ei;
        er = 12'(exp_re);
        ei = 12'(exp_im);
        checks++;
        assert (dout_real === er && dout_imag === ei) else begin
            errors++;
            $error("FAIL %s: observed re=%0d im=%0d expected re=%0d im=%0d",
                   tag, dout_real, dout_imag, er, ei);
        end
    endtask

    initial begin
        int k1_re;
        rst_n = 1'b1; halt_ctrl = 1'b1; mux_ctrl = 1'b0; tm_ctrl = 2'd0;
        din_real = '0; din_imag = '0;
        @(posedge clk);
        #1;
        check("reset_init", 0, 0);
        #1 rst_n = 1'b0;

        // Prime the stage so the async reset has non-zero state to clear.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 10, 20);
            check("prime_fill", 0, 0);
        end
        step(1, 1, 0, 5, 5);
        check("prime_sum", 15, 25);

        #2 rst_n = 1'b1;
        #1 check("async_reset", 0, 0);
        @(posedge clk);
        #1 check("reset_hold", 0, 0);
        #1 rst_n = 1'b0;

        // Fill right after reset reads an empty delay line: output is zero.
        step(1, 0, 0, 100, 200); check("fill0", 0, 0);
        step(1, 0, 0,  90, 180); check("fill1", 0, 0);
        step(1, 0, 0,  80, 160); check("fill2", 0, 0);
        step(1, 0, 0,  70, 140); check("fill3", 0, 0);

        step(1, 1, 0, 60, 120); check("bfly0", 160, 320);
        step(1, 1, 0, 50, 100); check("bfly1", 140, 280);
        step(1, 1, 0, 40,  80); check("bfly2", 120, 240);
        step(1, 1, 0, 30,  60); check("bfly3", 100, 200);

        // Differences are all 40+80j; meanwhile -512-512j is buffered.
`ifdef DIF_PE_ROUND_EN
        k1_re = 85;
`else
        k1_re = 84;
`endif
        step(1, 0, 0, -512, -512); check("tw_k0", 40, 80);
        step(1, 0, 1, -512, -512); check("tw_k1", k1_re, 28);
        step(1, 0, 2, -512, -512); check("tw_k2", 80, -40);
        step(1, 0, 3, -512, -512); check("tw_k3", 28, -85);

        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 511, 511);
            check("ext_sum", -1, -1);
        end

        // Extreme difference -1023-1023j through k=1, while filling the halt-test frame.
        step(1, 0, 1,  200, -100); check("ext_tw0", -1447, 0);
        step(1, 0, 1,  150,  -50); check("ext_tw1", -1447, 0);
        step(1, 0, 1, -100,   30); check("ext_tw2", -1447, 0);
        step(1, 0, 1, -250,  250); check("ext_tw3", -1447, 0);

        step(1, 1, 0,  20,  10); check("halt_bfly0", 220, -90);
        step(1, 1, 0, -30,  40); check("halt_bfly1", 120, -10);
        step(0, 1, 3, 333, -333); check("halt_hold0", 120, -10);
        step(0, 0, 2, -77,  99); check("halt_hold1", 120, -10);
        step(0, 1, 1, 511, -512); check("halt_hold2", 120, -10);
        step(1, 1, 0,  50, -60); check("halt_bfly2", -50, -30);
        step(1, 1, 0, 100, 100); check("halt_bfly3", -150, 350);

        // Read back the differences with W=1 to prove the delay line froze intact.
        step(1, 0, 0, 0, 0); check("halt_diff0",  180, -110);
        step(1, 0, 0, 0, 0); check("halt_diff1",  180,  -90);
        step(1, 0, 0, 0, 0); check("halt_diff2", -150,   90);
        step(1, 0, 0, 0, 0); check("halt_diff3", -350,  150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
